commit_trace_tx: RTL

Hardware transmitter for the processor's retirement and flush trace. It sits beside `top_processor`, samples the writeback-to-ARF commit stream, the flush controller's flush event and the fetch PC. It packs each event into a two-beat 32-bit record, buffers records in a small FIFO, and streams them out over a valid/ready port to an off-chip debug link or an on-chip trace memory. It produces in hardware the same commit/flush/hang information the simulation monitors print to text files.

---
 rtl/commit_trace_tx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/commit_trace_tx.sv
// commit_trace_tx: packs commit/flush/hang events into two-beat trace records,
// buffers them in a DEPTH-record FIFO and streams them out over valid/ready.
// Optional PC-stall watchdog enabled by defining COMMIT_TRACE_HANG_DETECT_EN.
module commit_trace_tx #(
  parameter int DEPTH       = 8,
  parameter int HANG_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid_i,
  input  logic        commit_flushed_i,
  input  logic        commit_write_i,
  input  logic [5:0]  commit_pdst_i,
  input  logic [31:0] commit_data_i,
  input  logic        flush_valid_i,
  input  logic [31:0] flush_address_i,
  input  logic [2:0]  flush_rob_ticket_i,
  input  logic [1:0]  flush_rat_id_i,
  input  logic        flush_delayed_i,
  input  logic [31:0] current_pc_i,
  output logic        trace_valid_o,
  output logic [31:0] trace_data_o,
  output logic        trace_last_o,
  input  logic        trace_ready_i,
  output logic        hang_o,
  output logic [15:0] drop_count_o,
  output logic        overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [31:0]   ts_reg;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, slot1_ptr;
  logic [AW:0]   count_reg, count_next, free_slots;
  logic          beat_reg;
  logic [15:0]   drop_reg, drop_next;
  logic [16:0]   drop_sum;
  logic          overflow_reg;

  logic          commit_ev, flush_ev, pop;
  logic [63:0]   commit_rec, flush_rec, hang_rec, slot0_rec, slot1_rec, head_rec;
  logic          hang_pend;
  logic [1:0]    avail, n_wr, n_drop;
  logic          c_wr, f_wr, h_wr;
  logic [63:0]   entry_q [DEPTH];

  assign commit_ev  = commit_valid_i & ~commit_flushed_i & commit_write_i;
  assign flush_ev   = flush_valid_i;
  assign commit_rec = {2'b01, commit_pdst_i, ts_reg[23:0], commit_data_i};
  assign flush_rec  = {2'b10, flush_rob_ticket_i, flush_rat_id_i, flush_delayed_i,
                       ts_reg[23:0], flush_address_i};

  // Slot allocation: commit first, then flush, hang only takes a leftover slot.
  // Free space ignores a same-cycle pop.
  always_comb begin
    free_slots = DEPTH_W - count_reg;
    avail      = (free_slots >= (AW+1)'(2)) ? 2'd2 : free_slots[1:0];
    c_wr       = commit_ev && (avail != 2'd0);
    f_wr       = flush_ev && ((avail == 2'd2) || ((avail == 2'd1) && !commit_ev));
    h_wr       = hang_pend && (({1'b0, c_wr} + {1'b0, f_wr}) < avail);
    n_wr       = {1'b0, c_wr} + {1'b0, f_wr} + {1'b0, h_wr};
    n_drop     = {1'b0, commit_ev & ~c_wr} + {1'b0, flush_ev & ~f_wr};
    slot0_rec  = c_wr ? commit_rec : (f_wr ? flush_rec : hang_rec);
    slot1_rec  = (c_wr && f_wr) ? flush_rec : hang_rec;
    slot1_ptr  = wr_ptr_reg + AW'(1);
    drop_sum   = {1'b0, drop_reg} + {15'd0, n_drop};
    drop_next  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [63:0] entry_reg;
      always_ff @(posedge clk) begin
        if (rst)
          entry_reg <= '0;
        else if ((n_wr != 2'd0) && (wr_ptr_reg == AW'(gi)))
          entry_reg <= slot0_rec;
        else if ((n_wr == 2'd2) && (slot1_ptr == AW'(gi)))
          entry_reg <= slot1_rec;
      end
      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  assign head_rec      = entry_q[rd_ptr_reg];
  assign trace_valid_o = (count_reg != '0);
  assign trace_last_o  = trace_valid_o & beat_reg;
  assign trace_data_o  = !trace_valid_o ? 32'd0 : (beat_reg ? head_rec[31:0] : head_rec[63:32]);
  assign pop           = trace_valid_o & trace_ready_i & beat_reg;
  assign count_next    = count_reg + (AW+1)'(n_wr) - (AW+1)'(pop);
  assign drop_count_o  = drop_reg;
  assign overflow_o    = overflow_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_reg       <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      beat_reg     <= 1'b0;
      drop_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      ts_reg     <= ts_reg + 32'd1;
      wr_ptr_reg <= wr_ptr_reg + AW'(n_wr);
      rd_ptr_reg <= rd_ptr_reg + AW'(pop);
      count_reg  <= count_next;
      if (trace_valid_o && trace_ready_i)
        beat_reg <= ~beat_reg;
      drop_reg     <= drop_next;
      overflow_reg <= overflow_reg | (n_drop != 2'd0);
    end
  end

`ifdef COMMIT_TRACE_HANG_DETECT_EN
  localparam int HCW = $clog2(HANG_CYCLES + 1);

  logic [31:0]  pc_reg;
  logic [HCW-1:0] stall_reg;
  logic         hang_reg, hang_pend_reg, stall_hit;
  logic [63:0]  hang_rec_reg;

  // Fires once, in the cycle the counter steps onto HANG_CYCLES.
  assign stall_hit = (current_pc_i == pc_reg) && (stall_reg == HCW'(HANG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg        <= '0;
      stall_reg     <= '0;
      hang_reg      <= 1'b0;
      hang_pend_reg <= 1'b0;
      hang_rec_reg  <= '0;
    end else begin
      if (current_pc_i != pc_reg) begin
        pc_reg    <= current_pc_i;
        stall_reg <= '0;
        hang_reg  <= 1'b0;
      end else if (stall_reg != HCW'(HANG_CYCLES)) begin
        stall_reg <= stall_reg + HCW'(1);
      end
      if (stall_hit) begin
        hang_reg     <= 1'b1;
        hang_rec_reg <= {2'b11, 6'd0, ts_reg[23:0], pc_reg};
      end
      hang_pend_reg <= (hang_pend_reg & ~h_wr) | stall_hit;
    end
  end

  assign hang_pend = hang_pend_reg;
  assign hang_rec  = hang_rec_reg;
  assign hang_o    = hang_reg;
`else
  localparam int unused_hang_cycles = HANG_CYCLES;
  logic unused_pc;
  assign unused_pc = ^current_pc_i;
  assign hang_pend = 1'b0;
  assign hang_rec  = '0;
  assign hang_o    = 1'b0;
`endif

endmodule
